// File: rtl/adc_sample_ctrl_pkg.sv
// Shared types and defaults for the serial ADC sample sequencer.
package adc_sample_ctrl_pkg;

  localparam int unsigned DATA_W            = 16;
  localparam int unsigned DEF_CLK_DIV       = 2;
  localparam int unsigned DEF_FRAME_BITS    = 16;
  localparam int unsigned DEF_SAMPLE_PERIOD = 2500;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CS_SETUP = 3'd1,
    ST_SHIFT    = 3'd2,
    ST_CS_HOLD  = 3'd3,
    ST_FLUSH    = 3'd4,
    ST_LATCH    = 3'd5
  } state_e;

  // clk cycles from the trigger cycle until sample_valid is seen high.
  function automatic int unsigned frame_latency(input int unsigned clk_div,
                                                input int unsigned frame_bits);
    return clk_div * (2 * frame_bits + 4) + 2;
  endfunction

endpackage

// File: rtl/adc_sample_ctrl_sclk_gen.sv
// SCLK generator: half-period down-counter plus the registered SCLK level.
// SCLK parks high whenever active_i is low; toggle_i selects toggling at terminal count.
module adc_sample_ctrl_sclk_gen
  import adc_sample_ctrl_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic active_i,
  input  logic toggle_i,
  output logic sclk_o,
  output logic tc_o
);

  localparam int unsigned     HC_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [HC_W-1:0] HC_LAST = HC_W'(CLK_DIV - 1);

  logic [HC_W-1:0] hc_q, hc_d;
  logic            sclk_q, sclk_d;
  logic            tc;

  always_comb begin
    tc     = active_i && (hc_q == '0);
    hc_d   = (!active_i || tc) ? HC_LAST : hc_q - HC_W'(1);
    sclk_d = sclk_q;
    if (!active_i) begin
      sclk_d = 1'b1;
    end else if (tc && toggle_i) begin
      sclk_d = !sclk_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hc_q   <= HC_LAST;
      sclk_q <= 1'b1;
    end else begin
      hc_q   <= hc_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk_o = sclk_q;
  assign tc_o   = tc;

endmodule

// File: rtl/adc_sample_ctrl.sv
// ADC frame sequencer: paces frames, drives CS/SCLK, captures the receiver word.
// state     | meaning
// IDLE      | waiting for start or timer wrap
// CS_SETUP  | CS low, SCLK high, one half-period
// SHIFT     | FRAME_BITS SCLK cycles, falling edge first
// CS_HOLD   | CS high, SCLK high, one half-period
// FLUSH     | one SCLK pulse with CS high to re-arm the receiver
// LATCH     | copy rx_data into the output register
module adc_sample_ctrl
  import adc_sample_ctrl_pkg::*;
#(
  parameter int unsigned CLK_DIV       = DEF_CLK_DIV,
  parameter int unsigned FRAME_BITS    = DEF_FRAME_BITS,
  parameter int unsigned SAMPLE_PERIOD = DEF_SAMPLE_PERIOD
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] rx_data_i,
  output logic              sclk_o,
  output logic              cs_o,
  output logic [DATA_W-1:0] sample_data_o,
  output logic              sample_valid_o,
  input  logic              sample_ready_i,
  output logic              overrun_o,
  input  logic              clear_ovr_i,
  output logic              busy_o
);

  localparam int unsigned      TMR_W    = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int unsigned      BC_W     = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SAMPLE_PERIOD - 1);
  localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(FRAME_BITS - 1);

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [BC_W-1:0]    bc_q, bc_d;
  logic               cs_q, cs_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               valid_q, valid_d;
  logic               ovr_q, ovr_d;
  logic               wrap, hc_tc, sclk, gen_active, gen_toggle, latch;

  adc_sample_ctrl_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .active_i (gen_active),
    .toggle_i (gen_toggle),
    .sclk_o   (sclk),
    .tc_o     (hc_tc)
  );

  // Free-running pacing timer; wraps raised while busy are simply lost.
  always_comb begin
    wrap    = enable_i && (timer_q == TMR_LAST);
    timer_d = (!enable_i || wrap) ? '0 : timer_q + TMR_W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      bc_q    <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bc_q    <= bc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bc_d    = bc_q;
    unique case (state_q)
      ST_IDLE:     if (start_i || wrap) state_d = ST_CS_SETUP;
      ST_CS_SETUP: if (hc_tc) state_d = ST_SHIFT;
      ST_SHIFT: begin
        if (hc_tc && sclk) begin
          if (bc_q == BC_LAST) begin
            state_d = ST_CS_HOLD;
            bc_d    = '0;
          end else begin
            bc_d = bc_q + BC_W'(1);
          end
        end
      end
      ST_CS_HOLD:  if (hc_tc) state_d = ST_FLUSH;
      ST_FLUSH:    if (hc_tc && sclk) state_d = ST_LATCH;
      ST_LATCH:    state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    gen_active = (state_q != ST_IDLE) && (state_q != ST_LATCH);
    unique case (state_q)
      ST_CS_SETUP, ST_CS_HOLD: gen_toggle = 1'b1;
      ST_SHIFT:                gen_toggle = !(sclk && (bc_q == BC_LAST));
      ST_FLUSH:                gen_toggle = !sclk;
      default:                 gen_toggle = 1'b0;
    endcase
    cs_d   = !((state_d == ST_CS_SETUP) || (state_d == ST_SHIFT));
    latch  = (state_q == ST_LATCH);
    busy_o = (state_q != ST_IDLE);
  end

  // Set of overrun takes priority over clear_ovr in the same cycle.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = clear_ovr_i ? 1'b0 : ovr_q;
    if (latch) begin
      data_d  = rx_data_i;
      valid_d = 1'b1;
      if (valid_q && !sample_ready_i) ovr_d = 1'b1;
    end else if (valid_q && sample_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cs_q    <= 1'b1;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      cs_q    <= cs_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign sclk_o         = sclk;
  assign cs_o           = cs_q;
  assign sample_data_o  = data_q;
  assign sample_valid_o = valid_q;
  assign overrun_o      = ovr_q;

endmodule

// File: tb/tb_adc_sample_ctrl.sv
// Bench for adc_sample_ctrl with a behavioural ADC (SDATA on SCLK fall) and receiver.
module tb_adc_sample_ctrl;

  localparam int P   = 2500;
  localparam int LAT = 2 * (2 * 16 + 4) + 2;

  typedef struct packed {
    logic       clr;
    logic       rdy;
    logic       exp_valid;
    logic       exp_ovr;
    logic [7:0] widx;
  } step_t;

  logic        clk, rst, enable, start, sample_ready, clear_ovr;
  logic [15:0] rx_sh;
  logic        sclk, cs, sample_valid, overrun, busy;
  logic [15:0] sample_data;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rises_lo = 0;
  int rises_hi = 0;
  int cs_falls = 0;
  int adc_idx  = 0;
  logic [15:0] adc_sh = '0;
  logic        sdata  = 1'b0;
  logic        cs_last = 1'b1;
  logic [15:0] exp_q[$];
  time         fall_t[$];
  step_t       steps[4];

  adc_sample_ctrl #(.CLK_DIV(2), .FRAME_BITS(16), .SAMPLE_PERIOD(P)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .enable_i       (enable),
    .start_i        (start),
    .rx_data_i      (rx_sh),
    .sclk_o         (sclk),
    .cs_o           (cs),
    .sample_data_o  (sample_data),
    .sample_valid_o (sample_valid),
    .sample_ready_i (sample_ready),
    .overrun_o      (overrun),
    .clear_ovr_i    (clear_ovr),
    .busy_o         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] word_of(input int k);
    return 16'h0ABC + 16'(k) * 16'h1357;
  endfunction

  // ADC model: loads a fresh word on CS fall, presents MSB first on each SCLK fall.
  always @(posedge cs or negedge cs or negedge sclk or posedge rst) begin
    if (rst) begin
      adc_idx = 0;
      cs_last = 1'b1;
    end else if (cs !== cs_last) begin
      cs_last = cs;
      if (cs === 1'b0) begin
        adc_sh = word_of(adc_idx);
        exp_q.push_back(adc_sh);
        fall_t.push_back($time);
        adc_idx++;
        cs_falls++;
      end
    end else if (cs === 1'b0 && sclk === 1'b0) begin
      sdata  = adc_sh[15];
      adc_sh = {adc_sh[14:0], 1'b0};
    end
  end

  always @(posedge sclk or posedge rst) begin
    if (rst) rx_sh <= '0;
    else if (cs === 1'b0) rx_sh <= {rx_sh[14:0], sdata};
  end

  always @(posedge sclk) begin
    if (cs === 1'b0) rises_lo++;
    else if (cs === 1'b1) rises_hi++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 'h%0h, want 'h%0h", name, act, exp);
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1; enable = 1'b0; start = 1'b0; sample_ready = 1'b0; clear_ovr = 1'b0;
    repeat (3) @(negedge clk);
    exp_q.delete();
    fall_t.delete();
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output int cnt);
    cnt = 1;
    @(negedge clk);
    while (sample_valid !== 1'b1 && cnt < budget) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({name, " idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int n, r0, h0, f0, c0, pops;
    steps[0] = '{clr: 1'b0, rdy: 1'b0, exp_valid: 1'b1, exp_ovr: 1'b0, widx: 8'd0};
    steps[1] = '{clr: 1'b0, rdy: 1'b0, exp_valid: 1'b1, exp_ovr: 1'b1, widx: 8'd1};
    steps[2] = '{clr: 1'b0, rdy: 1'b1, exp_valid: 1'b1, exp_ovr: 1'b1, widx: 8'd2};
    steps[3] = '{clr: 1'b1, rdy: 1'b0, exp_valid: 1'b1, exp_ovr: 1'b1, widx: 8'd3};

    // Reset values and a single start-triggered frame.
    reset_dut();
    chk("rst sclk", {31'd0, sclk}, 32'd1);
    chk("rst cs", {31'd0, cs}, 32'd1);
    chk("rst data", {16'd0, sample_data}, 32'd0);
    chk("rst valid", {31'd0, sample_valid}, 32'd0);
    chk("rst ovr", {31'd0, overrun}, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    r0 = rises_lo; h0 = rises_hi;
    pulse_start();
    chk("t1 cs low", {31'd0, cs}, 32'd0);
    chk("t1 busy", {31'd0, busy}, 32'd1);
    wait_valid(200, n);
    chk("t1 latency", 32'(n), 32'(LAT));
    chk("t1 data", {16'd0, sample_data}, {16'd0, word_of(0)});
    chk("t1 cs-low rises", 32'(rises_lo - r0), 32'd16);
    chk("t1 flush rises", 32'(rises_hi - h0), 32'd1);
    chk("t1 cs idle", {31'd0, cs}, 32'd1);
    chk("t1 sclk idle", {31'd0, sclk}, 32'd1);

    // Handshake / overrun table, one single-shot frame per entry.
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      clear_ovr = steps[i].clr;
      sample_ready = steps[i].rdy;
      @(negedge clk);
      clear_ovr = 1'b0;
      pulse_start();
      wait_idle($sformatf("t3[%0d]", i), 200);
      chk($sformatf("t3[%0d] valid", i), {31'd0, sample_valid}, {31'd0, steps[i].exp_valid});
      chk($sformatf("t3[%0d] ovr", i), {31'd0, overrun}, {31'd0, steps[i].exp_ovr});
      chk($sformatf("t3[%0d] data", i), {16'd0, sample_data}, {16'd0, word_of(int'(steps[i].widx))});
      sample_ready = 1'b0;
    end
    clear_ovr = 1'b1;
    @(negedge clk);
    clear_ovr = 1'b0;
    chk("t3 clear ovr", {31'd0, overrun}, 32'd0);
    chk("t3 valid kept", {31'd0, sample_valid}, 32'd1);

    // Ready asserted only in the LATCH cycle.
    pulse_start();
    repeat (72) @(posedge clk);
    @(negedge clk);
    sample_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sample_ready = 1'b0;
    chk("t4 valid", {31'd0, sample_valid}, 32'd1);
    chk("t4 ovr", {31'd0, overrun}, 32'd0);
    chk("t4 data", {16'd0, sample_data}, {16'd0, word_of(4)});
    chk("t4 busy", {31'd0, busy}, 32'd0);

    // Reset during bit 7 of a frame, then a clean frame.
    reset_dut();
    r0 = rises_lo;
    pulse_start();
    n = 0;
    while ((rises_lo - r0) < 7 && n < 200) begin @(negedge clk); n++; end
    while (sclk !== 1'b0 && n < 200) begin @(negedge clk); n++; end
    chk("t5 reached bit7", 32'(rises_lo - r0), 32'd7);
    rst = 1'b1;
    #1;
    chk("t5 cs abort", {31'd0, cs}, 32'd1);
    chk("t5 sclk abort", {31'd0, sclk}, 32'd1);
    chk("t5 busy abort", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pulse_start();
    wait_valid(200, n);
    chk("t5 valid", {31'd0, sample_valid}, 32'd1);
    chk("t5 data", {16'd0, sample_data}, {16'd0, word_of(0)});

    // Start coincident with timer wrap, start while busy, enable dropped mid-frame.
    reset_dut();
    f0 = cs_falls;
    enable = 1'b1;
    c0 = cyc;
    while (cyc < c0 + P - 1) @(negedge clk);
    chk("t6 cs before wrap", {31'd0, cs}, 32'd1);
    pulse_start();
    @(negedge clk);
    chk("t6 cs at wrap", {31'd0, cs}, 32'd0);
    repeat (20) @(negedge clk);
    pulse_start();
    while (cyc < c0 + P + 1000) @(negedge clk);
    chk("t6 one frame", 32'(cs_falls - f0), 32'd1);
    chk("t6 idle", {31'd0, busy}, 32'd0);
    while (cyc < c0 + 2 * P - 1) @(negedge clk);
    chk("t6 cs before wrap2", {31'd0, cs}, 32'd1);
    @(negedge clk);
    chk("t6 cs at wrap2", {31'd0, cs}, 32'd0);
    chk("t6 two frames", 32'(cs_falls - f0), 32'd2);
    enable = 1'b0;
    wait_idle("t6", 200);
    chk("t6 data", {16'd0, sample_data}, {16'd0, word_of(1)});
    chk("t6 ovr", {31'd0, overrun}, 32'd1);

    // Continuous timer-paced sampling with a scoreboard.
    reset_dut();
    sample_ready = 1'b1;
    enable = 1'b1;
    pops = 0; n = 0;
    while (pops < 10 && n < 11 * P) begin
      @(negedge clk);
      n++;
      if (sample_valid === 1'b1 && sample_ready) begin
        if (exp_q.size() == 0) begin
          chk("t2 scoreboard empty", 32'(exp_q.size()), 32'd1);
        end else begin
          chk($sformatf("t2 word%0d", pops), {16'd0, sample_data}, {16'd0, exp_q.pop_front()});
        end
        pops++;
      end
    end
    enable = 1'b0;
    chk("t2 word count", 32'(pops), 32'd10);
    chk("t2 ovr", {31'd0, overrun}, 32'd0);
    chk("t2 frame count", 32'(fall_t.size() >= 10), 32'd1);
    for (int i = 1; i < fall_t.size() && i < 10; i++) begin
      chk($sformatf("t2 period%0d", i), 32'((fall_t[i] - fall_t[i-1]) / 10), 32'(P));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
